// File: rtl/memshare_remap_ctrl.sv
// IB-LUT remap controller for a shared VN group: drains in-flight reads, reloads
// the IB-RAM rank from the LUT source, then grants decoder reads until the next remap.
module memshare_remap_ctrl #(
    parameter int unsigned SHARE_GROUP_SIZE = 4,
    parameter int unsigned QUAN_SIZE        = 4,
    parameter int unsigned REMAP_DEPTH      = 16,
    parameter int unsigned DP_LATENCY       = 3,
    parameter int unsigned ITER_WIDTH       = 5
) (
    input  logic                                  sys_clk,
    input  logic                                  rstn,
    input  logic                                  remap_start_i,
    input  logic [ITER_WIDTH-1:0]                 remap_iter_i,
    input  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] lut_data_i,
    input  logic                                  lut_valid_i,
    output logic                                  lut_ready_o,
    input  logic                                  rd_rqst_i,
    output logic                                  rd_grant_o,
    output logic                                  nRemap_en_o,
    output logic [$clog2(REMAP_DEPTH)-1:0]        remap_addr_o,
    output logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] remap_dataIn_vec_o,
    output logic [ITER_WIDTH-1:0]                 cur_iter_o,
    output logic                                  remap_done_o,
    output logic                                  busy_o,
    output logic                                  err_o
);

    localparam int unsigned AW = $clog2(REMAP_DEPTH);
    localparam int unsigned DW = QUAN_SIZE * SHARE_GROUP_SIZE;
    localparam logic [AW-1:0] LAST_ADDR = AW'(REMAP_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, DRAIN, LOAD, SETTLE, READY} state_e;

    state_e                  state_q;
    logic [DP_LATENCY-1:0]   hist_q;
    logic [DP_LATENCY-1:0]   hist_d;
    logic [AW-1:0]           cnt_q;
    logic [ITER_WIDTH-1:0]   pend_q;
    logic [ITER_WIDTH-1:0]   cur_q;
    logic [AW-1:0]           addr_q;
    logic [DW-1:0]           data_q;
    logic                    wen_n_q;
    logic                    done_q;
    logic                    err_q;
    logic                    beat;

    assign lut_ready_o = (state_q == LOAD);
    assign busy_o      = (state_q != READY);
    // A remap request in the same READY cycle takes priority over the read.
    assign rd_grant_o  = rd_rqst_i & (state_q == READY) & ~remap_start_i;
    assign beat        = lut_valid_i & lut_ready_o;
    // Grant history: nonzero while any read issued within DP_LATENCY cycles is in flight.
    assign hist_d      = DP_LATENCY'({hist_q, rd_grant_o});

    assign nRemap_en_o        = wen_n_q;
    assign remap_addr_o       = addr_q;
    assign remap_dataIn_vec_o = data_q;
    assign cur_iter_o         = cur_q;
    assign remap_done_o       = done_q;
    assign err_o              = err_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            hist_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            cur_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_n_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            wen_n_q <= 1'b1;
            done_q  <= 1'b0;
            if (beat) begin
                wen_n_q <= 1'b0;
                addr_q  <= cnt_q;
                data_q  <= lut_data_i;
                cnt_q   <= cnt_q + AW'(1);
            end
            if (remap_start_i && (state_q inside {DRAIN, LOAD, SETTLE})) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE, READY: begin
                    if (remap_start_i) begin
                        state_q <= DRAIN;
                        pend_q  <= remap_iter_i;
                    end
                end
                DRAIN: begin
                    if (hist_q == '0) state_q <= LOAD;
                end
                LOAD: begin
                    if (beat && (cnt_q == LAST_ADDR)) state_q <= SETTLE;
                end
                SETTLE: begin
                    state_q <= READY;
                    cur_q   <= pend_q;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/memshare_remap_ctrl.md
MEMSHARE_REMAP_CTRL -- requirements
Module: memshare_remap_ctrl

Interface
REQ-001 SHALL have parameter SHARE_GROUP_SIZE, default 4, VNUs per shared group.
REQ-002 SHALL have parameter QUAN_SIZE, default 4, IB-LUT entry width.
REQ-003 SHALL have parameter REMAP_DEPTH, default 16, IB-LUT words per remap (power of two); AW = log2(REMAP_DEPTH).
REQ-004 SHALL have parameter DP_LATENCY, default 3, read-to-V2C latency of the VN group datapath.
REQ-005 SHALL have parameter ITER_WIDTH, default 5, iteration index width.
REQ-006 sys_clk  input  1  single clock for all state.
REQ-007 rstn  input  1  reset; asynchronous, active-low.
REQ-008 remap_start_i  input  1  request reload of IB-LUT contents for iteration remap_iter_i.
REQ-009 remap_iter_i  input  ITER_WIDTH  iteration index of the requested contents.
REQ-010 lut_data_i  input  QUAN_SIZE*SHARE_GROUP_SIZE  one remap word from the LUT source.
REQ-011 lut_valid_i / lut_ready_o  input / output  1 each  valid/ready handshake for lut_data_i.
REQ-012 rd_rqst_i  input  1  decoder request to issue one read into the VN group.
REQ-013 rd_grant_o  output  1  read issued this cycle.
REQ-014 nRemap_en_o  output  1  active-low write enable to the IB-RAM rank.
REQ-015 remap_addr_o  output  AW  IB-RAM write word address.
REQ-016 remap_dataIn_vec_o  output  QUAN_SIZE*SHARE_GROUP_SIZE  IB-RAM write data.
REQ-017 cur_iter_o  output  ITER_WIDTH  iteration whose contents are loaded.
REQ-018 remap_done_o  output  1  one-cycle pulse, load complete.
REQ-019 busy_o / err_o  output  1 each  not in READY / sticky protocol error.

Function
REQ-020 FSM states IDLE, DRAIN, LOAD, SETTLE, READY; busy_o=1 in all but READY.
REQ-021 In-flight counter SHALL track grants over the last DP_LATENCY cycles (shift register of rd_grant_o).
REQ-022 IDLE or READY + remap_start_i -> DRAIN; latch remap_iter_i into pending register.
REQ-023 DRAIN -> LOAD in the first cycle the in-flight count is zero (may be the entry cycle+1; minimum one cycle in DRAIN).
REQ-024 LOAD: lut_ready_o=1; each beat (lut_valid_i & lut_ready_o) SHALL register lut_data_i to remap_dataIn_vec_o, address counter to remap_addr_o and drive nRemap_en_o=0 for exactly the next cycle.
REQ-025 Address counter SHALL start at 0, increment per beat, and after beat REMAP_DEPTH-1 wrap to 0 and move FSM to SETTLE.
REQ-026 lut_valid_i low in LOAD SHALL stall: nRemap_en_o=1, counter held, no timeout.
REQ-027 SETTLE lasts exactly 1 cycle (final write retires), then READY with cur_iter_o<=pending iteration and remap_done_o=1 for that cycle.
REQ-028 rd_grant_o = rd_rqst_i & (state==READY) & ~remap_start_i; requests outside READY are dropped, not queued.
REQ-029 remap_start_i and rd_rqst_i in the same READY cycle: remap wins, no grant.
REQ-030 remap_start_i in DRAIN, LOAD or SETTLE SHALL be ignored and set err_o; err_o clears only on reset.
REQ-031 lut_valid_i outside LOAD SHALL be ignored (lut_ready_o=0).
REQ-032 remap_addr_o and remap_dataIn_vec_o hold last written values when not writing.

Reset
REQ-033 rstn low SHALL asynchronously force: state IDLE, lut_ready_o=0, rd_grant_o=0, nRemap_en_o=1, remap_addr_o=0, remap_dataIn_vec_o=0, cur_iter_o=0, remap_done_o=0, err_o=0, in-flight history 0, busy_o=1.
REQ-034 Reset during LOAD SHALL abandon the load; no write after rstn deasserts until a new remap_start_i.
REQ-035 After reset, no read is granted until a first remap completes.

Verification
REQ-036 Reset, remap_start_i with iter 3, 16 back-to-back valid beats data 0x0000..0x000F -> 16 writes addr 0..15, nRemap_en_o low 16 cycles, remap_done_o one pulse, cur_iter_o=3.
REQ-037 READY, 3 consecutive grants then remap_start_i -> FSM stays in DRAIN until last grant is DP_LATENCY cycles old; lut_ready_o low throughout.
REQ-038 LOAD with lut_valid_i toggled every other cycle -> exactly 16 writes, addresses contiguous, no write on stall cycles.
REQ-039 remap_start_i during LOAD -> err_o=1 sticky, load continues, cur_iter_o keeps first request's iteration.
REQ-040 rd_rqst_i and remap_start_i same READY cycle -> rd_grant_o=0, busy_o=1 next cycle.
REQ-041 rstn pulsed low after 7 beats -> all outputs at reset values, next remap writes from address 0.
